// File: rtl/mem_arbiter.sv
// Multi-port arbiter in front of two asynchronous SRAM banks (BaseRAM, ExtRAM).
// Grants one request at a time, runs a fixed-length SRAM access and returns a single-cycle response.
module mem_arbiter #(
  parameter int          NPORT    = 2,
  parameter int          DATA_W   = 32,
  parameter int          BANK_AW  = 20,
  parameter int          WAIT_CYC = 2,
  parameter int          ARB_MODE = 0,
  parameter logic [31:0] BASE_LO  = 32'h8000_0000,
  parameter logic [31:0] EXT_LO   = 32'h8040_0000
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [NPORT-1:0]          req_valid,
  input  logic [NPORT-1:0]          req_we,
  input  logic [NPORT*DATA_W/8-1:0] req_be,
  input  logic [NPORT*32-1:0]       req_addr,
  input  logic [NPORT*DATA_W-1:0]   req_wdata,
  output logic [NPORT-1:0]          req_ready,

  output logic [NPORT-1:0]          rsp_valid,
  output logic [NPORT*DATA_W-1:0]   rsp_rdata,
  output logic [NPORT-1:0]          rsp_err,

  output logic                      base_ram_ce_n,
  output logic                      base_ram_oe_n,
  output logic                      base_ram_we_n,
  output logic [DATA_W/8-1:0]       base_ram_be_n,
  output logic [BANK_AW-1:0]        base_ram_addr,
  output logic [DATA_W-1:0]         base_ram_wdata,
  output logic                      base_ram_wdata_oe,
  input  logic [DATA_W-1:0]         base_ram_rdata,

  output logic                      ext_ram_ce_n,
  output logic                      ext_ram_oe_n,
  output logic                      ext_ram_we_n,
  output logic [DATA_W/8-1:0]       ext_ram_be_n,
  output logic [BANK_AW-1:0]        ext_ram_addr,
  output logic [DATA_W-1:0]         ext_ram_wdata,
  output logic                      ext_ram_wdata_oe,
  input  logic [DATA_W-1:0]         ext_ram_rdata
);

  localparam int          BE_W      = DATA_W / 8;
  localparam int          PW        = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int          SH        = $clog2(BE_W);
  localparam logic [63:0] BANK_SIZE = 64'd1 << (BANK_AW + SH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic [PW-1:0]       last_grant, grant;
  logic                accept;

  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                sel_we;
  logic                sel_hit_base, sel_hit_ext;
  logic [BANK_AW-1:0]  sel_word;

  logic [PW-1:0]       lat_port;
  logic                lat_we, lat_err, lat_ext;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   rdata_q;
  logic [BANK_AW-1:0]  base_addr_q, ext_addr_q;
  logic [DATA_W-1:0]   base_wdata_q, ext_wdata_q;
  logic                base_sel, ext_sel;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] last, input int offs);
    int v;
    v = (int'(last) + 1 + offs) % NPORT;
    return PW'(v);
  endfunction

  // Fixed mode: the last hit in an ascending scan is the highest index.
  // Round-robin: scanning from farthest to nearest leaves the nearest valid port after last_grant.
  always_comb begin
    grant = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NPORT; i++)
        if (req_valid[i]) grant = PW'(i);
    end else begin
      for (int i = NPORT - 1; i >= 0; i--)
        if (req_valid[rr_index(last_grant, i)]) grant = rr_index(last_grant, i);
    end
  end

  // Handshake: a request transfers on a clock edge where req_valid[p] and req_ready[p] are both 1.
  // req_ready is combinational, only ever one-hot in IDLE, and the payload is latched on that edge.
  assign accept = (state == IDLE) && !reset && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign sel_addr  = req_addr[32*int'(grant) +: 32];
  assign sel_wdata = req_wdata[DATA_W*int'(grant) +: DATA_W];
  assign sel_be    = req_be[BE_W*int'(grant) +: BE_W];
  assign sel_we    = req_we[grant];

  // 64-bit compare keeps the upper bound correct when a bank ends at the top of the 32-bit space.
  assign sel_hit_base = ({32'd0, sel_addr} >= {32'd0, BASE_LO}) &&
                        (({32'd0, sel_addr} - {32'd0, BASE_LO}) < BANK_SIZE);
  assign sel_hit_ext  = ({32'd0, sel_addr} >= {32'd0, EXT_LO}) &&
                        (({32'd0, sel_addr} - {32'd0, EXT_LO}) < BANK_SIZE);
  assign sel_word     = sel_hit_base ? BANK_AW'((sel_addr - BASE_LO) >> SH)
                                     : BANK_AW'((sel_addr - EXT_LO) >> SH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (sel_hit_base || sel_hit_ext) ? ACCESS : RESP;
      ACCESS:  if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= 4'd0;
      last_grant   <= PW'(NPORT - 1);
      lat_port     <= '0;
      lat_we       <= 1'b0;
      lat_err      <= 1'b0;
      lat_ext      <= 1'b0;
      lat_be       <= '0;
      rdata_q      <= '0;
      base_addr_q  <= '0;
      ext_addr_q   <= '0;
      base_wdata_q <= '0;
      ext_wdata_q  <= '0;
    end else if (accept) begin
      last_grant <= grant;
      lat_port   <= grant;
      lat_we     <= sel_we;
      lat_be     <= sel_be;
      lat_err    <= !(sel_hit_base || sel_hit_ext);
      lat_ext    <= !sel_hit_base && sel_hit_ext;
      rdata_q    <= '0;
      cnt        <= 4'(WAIT_CYC - 1);
      if (sel_hit_base) begin
        base_addr_q <= sel_word;
        if (sel_we) base_wdata_q <= sel_wdata;
      end else if (sel_hit_ext) begin
        ext_addr_q <= sel_word;
        if (sel_we) ext_wdata_q <= sel_wdata;
      end
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        if (!lat_we) rdata_q <= lat_ext ? ext_ram_rdata : base_ram_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Decode errors never enter ACCESS, so neither bank is strobed for them.
  assign base_sel = (state == ACCESS) && !lat_ext;
  assign ext_sel  = (state == ACCESS) && lat_ext;

  assign base_ram_ce_n     = !base_sel;
  assign base_ram_oe_n     = !(base_sel && !lat_we);
  assign base_ram_we_n     = !(base_sel && lat_we);
  assign base_ram_be_n     = base_sel ? ~lat_be : {BE_W{1'b1}};
  assign base_ram_wdata_oe = base_sel && lat_we;
  assign base_ram_addr     = base_addr_q;
  assign base_ram_wdata    = base_wdata_q;

  assign ext_ram_ce_n      = !ext_sel;
  assign ext_ram_oe_n      = !(ext_sel && !lat_we);
  assign ext_ram_we_n      = !(ext_sel && lat_we);
  assign ext_ram_be_n      = ext_sel ? ~lat_be : {BE_W{1'b1}};
  assign ext_ram_wdata_oe  = ext_sel && lat_we;
  assign ext_ram_addr      = ext_addr_q;
  assign ext_ram_wdata     = ext_wdata_q;

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = '0;
    if (state == RESP) begin
      rsp_valid[lat_port]                           = 1'b1;
      rsp_rdata[DATA_W*int'(lat_port) +: DATA_W]    = rdata_q;
      rsp_err[lat_port]                             = lat_err;
    end
  end

endmodule
